muldiv_ctrl: RTL and testbench
==============================

MULDIV_CTRL -- requirements
Module: muldiv_ctrl

Parameters
REQ-001 SHALL provide parameter TIMEOUT, default 64: max WAIT-state cycles before abort.

Interface
REQ-002 SHALL have port clock  input  1  sole clock, rising edge.
REQ-003 SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have ports op_mult, op_div, op_mfhi, op_mflo  input  1 each  single-cycle decoded requests.
REQ-005 SHALL have ports rs_data, rt_data  input  32 each  operands (rs = multiplicand/dividend, rt = multiplier/divisor).
REQ-006 SHALL have ports mult_start, div_start  output  1 each  one-cycle start pulses to the arithmetic units.
REQ-007 SHALL have ports op_a, op_b  output  32 each  operands held stable to both units from START through WAIT.
REQ-008 SHALL have ports mult_hi, mult_lo, div_hi, div_lo  input  32 each  unit results.
REQ-009 SHALL have ports mult_busy, div_busy  input  1 each  unit in-progress flags.
REQ-010 SHALL have ports hi, lo  output  32 each  architectural HI/LO registers.
REQ-011 SHALL have port rd_data  output  32  mfhi/mflo result.
REQ-012 SHALL have port stall  output  1  pipeline hold while an operation is in flight.
REQ-013 SHALL have ports div_zero, timeout_err  output  1 each  sticky error flags.

Function
REQ-014 SHALL implement FSM states IDLE, START, WAIT, CAPTURE; encoding free.
REQ-015 IDLE: op_mult or op_div SHALL latch rs_data/rt_data into op_a/op_b, latch op type, go to START; op_mult wins if both are asserted.
REQ-016 IDLE with op_div and rt_data == 0: SHALL set div_zero, leave hi/lo unchanged, and stay in IDLE; no start pulse.
REQ-017 START: SHALL assert the selected start pulse for exactly one cycle, clear the wait counter, then go to WAIT.
REQ-018 WAIT: SHALL ignore busy on the first WAIT cycle, then go to CAPTURE on the first cycle the selected busy == 0.
REQ-019 WAIT: SHALL increment a wait counter each cycle; if it reaches TIMEOUT, SHALL set timeout_err, leave hi/lo unchanged, and return to IDLE.
REQ-020 CAPTURE: SHALL load hi/lo from the selected unit's hi/lo in one cycle, then return to IDLE.
REQ-021 stall SHALL be 1 in START, WAIT, and CAPTURE, and also combinationally whenever any op_* is asserted while the FSM is not in IDLE.
REQ-022 Requests arriving while not in IDLE SHALL be ignored; upstream holds them under stall.
REQ-023 op_mfhi/op_mflo in IDLE: rd_data SHALL equal hi/lo combinationally in the same cycle; otherwise rd_data SHALL be 0.
REQ-024 op_mfhi and op_mflo together: SHALL return hi.
REQ-025 Mult/div latency seen by the pipeline SHALL be 1 (START) + busy duration + 1 (first WAIT) + 1 (CAPTURE) cycles.
REQ-026 div_zero and timeout_err SHALL clear only on reset.

Reset
REQ-027 reset_n low SHALL immediately force IDLE, hi = lo = op_a = op_b = 0, rd_data = 0, start pulses = 0, stall = 0, and both error flags = 0.
REQ-028 Reset asserted mid-operation SHALL abort without capture; the first request after deassertion SHALL start normally.

Verification
REQ-029 op_mult, rs = 7, rt = 6, mult_busy high 32 cycles -> one mult_start pulse, stall high throughout, then hi = 0, lo = 42 (model outputs), then op_mflo returns 42.
REQ-030 op_div, rs = 100, rt = 0 -> no div_start, div_zero = 1, hi/lo unchanged, stall stays 0.
REQ-031 op_mult with mult_busy stuck at 1, TIMEOUT = 64 -> timeout_err = 1 after 64 WAIT cycles, FSM back in IDLE, hi/lo unchanged.
REQ-032 op_div issued during WAIT of a mult -> ignored, stall = 1; after capture, the reissued div runs normally.
REQ-033 reset_n pulsed low in WAIT -> all outputs 0 at once; a following op_mult completes correctly.
REQ-034 op_mfhi and op_mflo together with hi = 0xDEADBEEF, lo = 1 -> rd_data = 0xDEADBEEF.

Source files
------------

// File: rtl/muldiv_ctrl.sv
// Multiply/divide sequencer: issues start pulses to the external arithmetic units,
// waits on their busy flags with a timeout, and maintains the architectural HI/LO pair.
module muldiv_ctrl #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        op_mult,
    input  logic        op_div,
    input  logic        op_mfhi,
    input  logic        op_mflo,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    output logic        mult_start,
    output logic        div_start,
    output logic [31:0] op_a,
    output logic [31:0] op_b,
    input  logic [31:0] mult_hi,
    input  logic [31:0] mult_lo,
    input  logic [31:0] div_hi,
    input  logic [31:0] div_lo,
    input  logic        mult_busy,
    input  logic        div_busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] rd_data,
    output logic        stall,
    output logic        div_zero,
    output logic        timeout_err
);
    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] START   = 2'd1;
    localparam logic [1:0] WAIT    = 2'd2;
    localparam logic [1:0] CAPTURE = 2'd3;

    logic [1:0]    state, state_nxt;
    logic [CW-1:0] wait_cnt, wait_cnt_nxt;
    logic          sel_div, sel_div_nxt;
    logic          load_ops;
    logic          capture;
    logic          set_dz;
    logic          set_to;
    logic          mult_start_nxt;
    logic          div_start_nxt;
    logic          sel_busy;

    assign sel_busy = sel_div ? div_busy : mult_busy;

    // Next-state and control decode
    always_comb begin
        state_nxt      = state;
        wait_cnt_nxt   = wait_cnt;
        sel_div_nxt    = sel_div;
        load_ops       = 1'b0;
        capture        = 1'b0;
        set_dz         = 1'b0;
        set_to         = 1'b0;
        mult_start_nxt = 1'b0;
        div_start_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (op_mult) begin
                    load_ops       = 1'b1;
                    sel_div_nxt    = 1'b0;
                    mult_start_nxt = 1'b1;
                    state_nxt      = START;
                end else if (op_div) begin
                    if (rt_data == 32'd0) begin
                        set_dz = 1'b1;
                    end else begin
                        load_ops      = 1'b1;
                        sel_div_nxt   = 1'b1;
                        div_start_nxt = 1'b1;
                        state_nxt     = START;
                    end
                end
            end
            START: begin
                wait_cnt_nxt = '0;
                state_nxt    = WAIT;
            end
            WAIT: begin
                wait_cnt_nxt = wait_cnt + CW'(1);
                // Busy is not trusted on the first WAIT cycle: the unit may not have reacted yet
                if ((wait_cnt != '0) && !sel_busy) begin
                    state_nxt = CAPTURE;
                end else if (wait_cnt_nxt == CW'(TIMEOUT)) begin
                    set_to    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            CAPTURE: begin
                capture   = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Operand, result, pulse and sticky-flag registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wait_cnt    <= '0;
            sel_div     <= 1'b0;
            op_a        <= 32'd0;
            op_b        <= 32'd0;
            hi          <= 32'd0;
            lo          <= 32'd0;
            mult_start  <= 1'b0;
            div_start   <= 1'b0;
            div_zero    <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            wait_cnt   <= wait_cnt_nxt;
            sel_div    <= sel_div_nxt;
            mult_start <= mult_start_nxt;
            div_start  <= div_start_nxt;
            if (load_ops) begin
                op_a <= rs_data;
                op_b <= rt_data;
            end
            if (capture) begin
                hi <= sel_div ? div_hi : mult_hi;
                lo <= sel_div ? div_lo : mult_lo;
            end
            if (set_dz) begin
                div_zero <= 1'b1;
            end
            if (set_to) begin
                timeout_err <= 1'b1;
            end
        end
    end

    // Any request seen outside IDLE is already covered since stall is high there
    assign stall = (state != IDLE);

    always_comb begin
        rd_data = 32'd0;
        if (state == IDLE) begin
            if (op_mfhi) begin
                rd_data = hi;
            end else if (op_mflo) begin
                rd_data = lo;
            end
        end
    end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl with behavioural multiply/divide unit models.
module tb_muldiv_ctrl;
    logic        clock;
    logic        reset_n;
    logic        op_mult, op_div, op_mfhi, op_mflo;
    logic [31:0] rs_data, rt_data;
    logic        mult_start, div_start;
    logic [31:0] op_a, op_b;
    logic [31:0] mult_hi, mult_lo, div_hi, div_lo;
    logic        mult_busy, div_busy;
    logic [31:0] hi, lo, rd_data;
    logic        stall, div_zero, timeout_err;

    int vectors = 0;
    int errors  = 0;

    int          mult_dur = 32;
    int          div_dur  = 3;
    bit          mult_stuck = 1'b0;
    bit          ovr_en = 1'b0;
    logic [31:0] ovr_hi = 32'd0;
    logic [31:0] ovr_lo = 32'd0;
    int          mult_cnt, div_cnt;

    muldiv_ctrl #(.TIMEOUT(64)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .op_mult     (op_mult),
        .op_div      (op_div),
        .op_mfhi     (op_mfhi),
        .op_mflo     (op_mflo),
        .rs_data     (rs_data),
        .rt_data     (rt_data),
        .mult_start  (mult_start),
        .div_start   (div_start),
        .op_a        (op_a),
        .op_b        (op_b),
        .mult_hi     (mult_hi),
        .mult_lo     (mult_lo),
        .div_hi      (div_hi),
        .div_lo      (div_lo),
        .mult_busy   (mult_busy),
        .div_busy    (div_busy),
        .hi          (hi),
        .lo          (lo),
        .rd_data     (rd_data),
        .stall       (stall),
        .div_zero    (div_zero),
        .timeout_err (timeout_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Arithmetic unit models: busy for a programmable number of cycles after start
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mult_cnt <= 0;
            div_cnt  <= 0;
            mult_hi  <= 32'd0;
            mult_lo  <= 32'd0;
            div_hi   <= 32'd0;
            div_lo   <= 32'd0;
        end else begin
            if (mult_start) begin
                mult_cnt <= mult_dur;
                if (ovr_en) {mult_hi, mult_lo} <= {ovr_hi, ovr_lo};
                else        {mult_hi, mult_lo} <= 64'(op_a) * 64'(op_b);
            end else if (mult_cnt > 0) begin
                mult_cnt <= mult_cnt - 1;
            end
            if (div_start) begin
                div_cnt <= div_dur;
                div_hi  <= op_a % op_b;
                div_lo  <= op_a / op_b;
            end else if (div_cnt > 0) begin
                div_cnt <= div_cnt - 1;
            end
        end
    end
    assign mult_busy = mult_stuck || (mult_cnt != 0);
    assign div_busy  = (div_cnt != 0);

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Counts cycles with stall high, bounded so a stuck DUT still reaches the summary
    task automatic run_until_idle(output int cycles, output int mstarts, output int dstarts);
        cycles = 0; mstarts = 0; dstarts = 0;
        while (stall === 1'b1 && cycles < 500) begin
            cycles++;
            if (mult_start === 1'b1) mstarts++;
            if (div_start === 1'b1) dstarts++;
            tick();
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        op_mult = 0; op_div = 0; op_mfhi = 0; op_mflo = 0;
        rs_data = 0; rt_data = 0;
        repeat (2) @(posedge clock);
        #1;
        vectors++; if (hi !== 32'd0) begin errors++; $display("FAIL reset_hi: got %h expected 0", hi); end
        vectors++; if (lo !== 32'd0) begin errors++; $display("FAIL reset_lo: got %h expected 0", lo); end
        vectors++; if (op_a !== 32'd0 || op_b !== 32'd0) begin errors++; $display("FAIL reset_ops: got %h/%h expected 0/0", op_a, op_b); end
        vectors++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", stall); end
        vectors++; if (mult_start !== 1'b0 || div_start !== 1'b0) begin errors++; $display("FAIL reset_start: got %b/%b expected 0/0", mult_start, div_start); end
        vectors++; if (div_zero !== 1'b0 || timeout_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b/%b expected 0/0", div_zero, timeout_err); end
        vectors++; if (rd_data !== 32'd0) begin errors++; $display("FAIL reset_rd: got %h expected 0", rd_data); end
        @(negedge clock);
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_mult();
        int c, m, d;
        rs_data = 32'd7; rt_data = 32'd6; op_mult = 1'b1;
        tick();
        op_mult = 1'b0;
        vectors++; if (mult_start !== 1'b1) begin errors++; $display("FAIL mult_start: got %b expected 1", mult_start); end
        vectors++; if (op_a !== 32'd7 || op_b !== 32'd6) begin errors++; $display("FAIL mult_ops: got %0d/%0d expected 7/6", op_a, op_b); end
        run_until_idle(c, m, d);
        vectors++; if (c !== 35) begin errors++; $display("FAIL mult_stall_cycles: got %0d expected 35", c); end
        vectors++; if (m !== 1 || d !== 0) begin errors++; $display("FAIL mult_pulses: got %0d/%0d expected 1/0", m, d); end
        vectors++; if (hi !== 32'd0 || lo !== 32'd42) begin errors++; $display("FAIL mult_result: got %0d/%0d expected 0/42", hi, lo); end
        op_mflo = 1'b1; #1;
        vectors++; if (rd_data !== 32'd42) begin errors++; $display("FAIL mflo: got %0d expected 42", rd_data); end
        vectors++; if (stall !== 1'b0) begin errors++; $display("FAIL mflo_stall: got %b expected 0", stall); end
        op_mflo = 1'b0;
        tick();
    endtask

    task automatic test_div_zero();
        rs_data = 32'd100; rt_data = 32'd0; op_div = 1'b1;
        #1;
        vectors++; if (stall !== 1'b0) begin errors++; $display("FAIL dz_stall_comb: got %b expected 0", stall); end
        tick();
        op_div = 1'b0;
        vectors++; if (div_start !== 1'b0) begin errors++; $display("FAIL dz_no_start: got %b expected 0", div_start); end
        vectors++; if (div_zero !== 1'b1) begin errors++; $display("FAIL dz_flag: got %b expected 1", div_zero); end
        vectors++; if (stall !== 1'b0) begin errors++; $display("FAIL dz_stall: got %b expected 0", stall); end
        vectors++; if (hi !== 32'd0 || lo !== 32'd42) begin errors++; $display("FAIL dz_hilo: got %0d/%0d expected 0/42", hi, lo); end
        tick();
        vectors++; if (div_start !== 1'b0) begin errors++; $display("FAIL dz_no_start_late: got %b expected 0", div_start); end
    endtask

    task automatic test_timeout();
        int c, m, d;
        vectors++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL to_pre: got %b expected 0", timeout_err); end
        mult_stuck = 1'b1;
        rs_data = 32'd3; rt_data = 32'd5; op_mult = 1'b1;
        tick();
        op_mult = 1'b0;
        run_until_idle(c, m, d);
        vectors++; if (c !== 65) begin errors++; $display("FAIL to_cycles: got %0d expected 65", c); end
        vectors++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL to_flag: got %b expected 1", timeout_err); end
        vectors++; if (hi !== 32'd0 || lo !== 32'd42) begin errors++; $display("FAIL to_hilo: got %0d/%0d expected 0/42", hi, lo); end
        vectors++; if (div_zero !== 1'b1) begin errors++; $display("FAIL dz_sticky: got %b expected 1", div_zero); end
        mult_stuck = 1'b0;
        tick();
        vectors++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL to_sticky: got %b expected 1", timeout_err); end
    endtask

    task automatic test_back_to_back();
        int c, m, d;
        mult_dur = 4;
        rs_data = 32'd9; rt_data = 32'd11; op_mult = 1'b1;
        tick();
        op_mult = 1'b0;
        tick();
        tick();
        rs_data = 32'd100; rt_data = 32'd7; op_div = 1'b1; op_mfhi = 1'b1;
        #1;
        vectors++; if (stall !== 1'b1) begin errors++; $display("FAIL b2b_stall: got %b expected 1", stall); end
        vectors++; if (rd_data !== 32'd0) begin errors++; $display("FAIL b2b_rd_busy: got %h expected 0", rd_data); end
        vectors++; if (op_a !== 32'd9) begin errors++; $display("FAIL b2b_op_hold: got %0d expected 9", op_a); end
        op_mfhi = 1'b0;
        run_until_idle(c, m, d);
        vectors++; if (c !== 5) begin errors++; $display("FAIL b2b_mult_cycles: got %0d expected 5", c); end
        vectors++; if (d !== 0) begin errors++; $display("FAIL b2b_div_ignored: got %0d expected 0", d); end
        vectors++; if (hi !== 32'd0 || lo !== 32'd99) begin errors++; $display("FAIL b2b_mult_res: got %0d/%0d expected 0/99", hi, lo); end
        tick();
        op_div = 1'b0;
        vectors++; if (div_start !== 1'b1) begin errors++; $display("FAIL b2b_div_start: got %b expected 1", div_start); end
        vectors++; if (op_a !== 32'd100 || op_b !== 32'd7) begin errors++; $display("FAIL b2b_div_ops: got %0d/%0d expected 100/7", op_a, op_b); end
        run_until_idle(c, m, d);
        vectors++; if (c !== 6) begin errors++; $display("FAIL b2b_div_cycles: got %0d expected 6", c); end
        vectors++; if (hi !== 32'd2 || lo !== 32'd14) begin errors++; $display("FAIL b2b_div_res: got %0d/%0d expected 2/14", hi, lo); end
        mult_dur = 32;
        tick();
    endtask

    task automatic test_reset_mid();
        int c, m, d;
        rs_data = 32'd2; rt_data = 32'd3; op_mult = 1'b1;
        tick();
        op_mult = 1'b0;
        repeat (5) tick();
        vectors++; if (stall !== 1'b1) begin errors++; $display("FAIL rm_pre_stall: got %b expected 1", stall); end
        reset_n = 1'b0; op_mfhi = 1'b1;
        #1;
        vectors++; if (hi !== 32'd0 || lo !== 32'd0) begin errors++; $display("FAIL rm_hilo: got %h/%h expected 0/0", hi, lo); end
        vectors++; if (op_a !== 32'd0 || op_b !== 32'd0) begin errors++; $display("FAIL rm_ops: got %h/%h expected 0/0", op_a, op_b); end
        vectors++; if (stall !== 1'b0) begin errors++; $display("FAIL rm_stall: got %b expected 0", stall); end
        vectors++; if (div_zero !== 1'b0 || timeout_err !== 1'b0) begin errors++; $display("FAIL rm_err: got %b/%b expected 0/0", div_zero, timeout_err); end
        vectors++; if (rd_data !== 32'd0) begin errors++; $display("FAIL rm_rd: got %h expected 0", rd_data); end
        op_mfhi = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        tick();
        rs_data = 32'h0001_0000; rt_data = 32'h0001_0000; op_mult = 1'b1;
        tick();
        op_mult = 1'b0;
        vectors++; if (mult_start !== 1'b1) begin errors++; $display("FAIL rm_restart: got %b expected 1", mult_start); end
        run_until_idle(c, m, d);
        vectors++; if (c !== 35) begin errors++; $display("FAIL rm_cycles: got %0d expected 35", c); end
        vectors++; if (hi !== 32'd1 || lo !== 32'd0) begin errors++; $display("FAIL rm_result: got %h/%h expected 1/0", hi, lo); end
        tick();
    endtask

    task automatic test_mfhi_mflo();
        int c, m, d;
        ovr_en = 1'b1; ovr_hi = 32'hDEAD_BEEF; ovr_lo = 32'd1;
        rs_data = 32'd5; rt_data = 32'd0; op_mult = 1'b1; op_div = 1'b1;
        tick();
        op_mult = 1'b0; op_div = 1'b0;
        vectors++; if (mult_start !== 1'b1 || div_start !== 1'b0) begin errors++; $display("FAIL prio_start: got %b/%b expected 1/0", mult_start, div_start); end
        vectors++; if (div_zero !== 1'b0) begin errors++; $display("FAIL prio_dz: got %b expected 0", div_zero); end
        run_until_idle(c, m, d);
        vectors++; if (hi !== 32'hDEAD_BEEF || lo !== 32'd1) begin errors++; $display("FAIL mf_hilo: got %h/%h expected deadbeef/1", hi, lo); end
        op_mfhi = 1'b1; op_mflo = 1'b1; #1;
        vectors++; if (rd_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL mf_both: got %h expected deadbeef", rd_data); end
        op_mfhi = 1'b0; #1;
        vectors++; if (rd_data !== 32'd1) begin errors++; $display("FAIL mf_lo: got %h expected 1", rd_data); end
        op_mflo = 1'b0; #1;
        vectors++; if (rd_data !== 32'd0) begin errors++; $display("FAIL mf_none: got %h expected 0", rd_data); end
        ovr_en = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div_zero();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        test_mfhi_mflo();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
